// File: rtl/iob_cache_repl_sequencer.sv
// Replacement-policy access sequencer: hit/miss lookups, victim hold, policy commit, flush sweep.
// Optional hit/miss statistics counters are built when IOB_CACHE_REPL_STATS_EN is defined.
module iob_cache_repl_sequencer #(
  parameter int N_WAYS   = 8,
  parameter int NLINES_W = 7,
  parameter int NWAYS_W  = $clog2(N_WAYS),
  parameter int CNT_W    = 32
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                arst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [NLINES_W-1:0] req_line_i,
  input  logic [N_WAYS-1:0]   req_way_hit_i,
  input  logic                fill_done_i,
  input  logic                flush_i,
  output logic                flush_busy_o,
  output logic                victim_valid_o,
  output logic [NWAYS_W-1:0]  victim_way_o,
  output logic                pol_we_o,
  output logic                pol_flush_o,
  output logic [NLINES_W-1:0] pol_line_o,
  output logic [N_WAYS-1:0]   pol_way_hit_o,
  input  logic [NWAYS_W-1:0]  pol_way_select_bin_i
`ifdef IOB_CACHE_REPL_STATS_EN
  ,
  input  logic                stats_clr_i,
  output logic [CNT_W-1:0]    hit_cnt_o,
  output logic [CNT_W-1:0]    miss_cnt_o
`endif
);

  if (N_WAYS < 2 || (1 << NWAYS_W) != N_WAYS || CNT_W < 1) begin : g_param_check
    $error("iob_cache_repl_sequencer: illegal N_WAYS/NWAYS_W/CNT_W");
  end

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_WAIT, UPDATE, FLUSH} state_t;

  localparam logic [NLINES_W-1:0] LINE_ONE = 1;
  localparam logic [N_WAYS-1:0]   WAY_ONE  = 1;

  state_t              state, state_nxt;
  logic [NLINES_W-1:0] line_q;
  logic [NLINES_W-1:0] flush_cnt;
  logic [N_WAYS-1:0]   hit_q;
  logic                ready_q;
  logic                flush_pend, pend_nxt;
  logic                accept;
  logic                req_hit;

  assign req_ready_o = ready_q & cke_i & ~flush_i;
  assign accept      = req_valid_i & req_ready_o;
  assign req_hit     = |req_way_hit_i;

  always_comb begin
    state_nxt     = state;
    pend_nxt      = flush_pend;
    flush_busy_o  = 1'b0;
    pol_we_o      = 1'b0;
    pol_flush_o   = 1'b0;
    pol_line_o    = '0;
    pol_way_hit_o = '0;
    case (state)
      IDLE: begin
        if (flush_i || flush_pend) begin
          state_nxt = FLUSH;
          pend_nxt  = 1'b0;
        end else if (accept) begin
          state_nxt = req_hit ? UPDATE : LOOKUP;
        end
      end
      LOOKUP: begin
        pol_line_o = line_q;
        state_nxt  = MISS_WAIT;
        if (flush_i) pend_nxt = 1'b1;
      end
      MISS_WAIT: begin
        if (fill_done_i) state_nxt = UPDATE;
        if (flush_i) pend_nxt = 1'b1;
      end
      UPDATE: begin
        pol_we_o      = 1'b1;
        pol_line_o    = line_q;
        pol_way_hit_o = hit_q;
        state_nxt     = IDLE;
        if (flush_i) pend_nxt = 1'b1;
      end
      FLUSH: begin
        flush_busy_o = 1'b1;
        pol_we_o     = 1'b1;
        pol_flush_o  = 1'b1;
        pol_line_o   = flush_cnt;
        if (flush_cnt == '1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state; ready re-arms one cycle after an update has committed.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state          <= IDLE;
      flush_pend     <= 1'b0;
      flush_cnt      <= '0;
      ready_q        <= 1'b0;
      victim_valid_o <= 1'b0;
      victim_way_o   <= '0;
    end else if (cke_i) begin
      state      <= state_nxt;
      flush_pend <= pend_nxt;
      flush_cnt  <= (state == FLUSH) ? flush_cnt + LINE_ONE : '0;
      ready_q    <= (state_nxt == IDLE) && !pend_nxt && (state != UPDATE);
      if (state == LOOKUP) begin
        victim_valid_o <= 1'b1;
        victim_way_o   <= pol_way_select_bin_i;
      end else if (state == UPDATE) begin
        victim_valid_o <= 1'b0;
      end
    end
  end

  // Request data; only consumed in states that first load it.
  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (state == IDLE && accept) begin
        line_q <= req_line_i;
        hit_q  <= req_way_hit_i;
      end else if (state == MISS_WAIT && fill_done_i) begin
        hit_q <= WAY_ONE << victim_way_o;
      end
    end
  end

`ifdef IOB_CACHE_REPL_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (cke_i) begin
      if (stats_clr_i) begin
        hit_cnt_o  <= '0;
        miss_cnt_o <= '0;
      end else if (accept) begin
        if (req_hit) hit_cnt_o  <= sat_inc(hit_cnt_o);
        else         miss_cnt_o <= sat_inc(miss_cnt_o);
      end
    end
  end
`endif

endmodule
